// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: shares one external LFSR among NREQ requesters.
// After reset the LFSR is held in reset, then warmed up, then each grant
// steps it exactly once so every requester gets a fresh state.
// Handshake: a requester holds req[i] high until gnt[i] pulses for one
// cycle; rnd_data is valid only in that cycle (rnd_valid == |gnt).
// Optional feature: define LFSR_LOCKUP_DET_EN to treat an all-zero LFSR
// value in GRANT as a lockup (re-init, count it, re-serve the same winner).
// The enum state is exported on dbg_state.
module lfsr_rng_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int RST_CYC = 2,
  parameter int WARMUP  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             busy,
  output logic             lfsr_reset,
  output logic             lfsr_enable,
  input  logic [WIDTH-1:0] lfsr_value,
  output logic [2:0]       dbg_state
`ifdef LFSR_LOCKUP_DET_EN
  ,
  output logic [7:0]       lockup_cnt
`endif
);

  localparam int PW = $clog2(NREQ);
  // INIT is left on the edge after the counter reaches RST_CYC, so the
  // reset-release cycle plus RST_CYC full cycles see lfsr_reset high.
  localparam logic [15:0] RST_LAST  = 16'(RST_CYC);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_WARM  = 3'd1,
    S_IDLE  = 3'd2,
    S_STEP  = 3'd3,
    S_GRANT = 3'd4
  } state_t;

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     idx_q;
  logic [NREQ-1:0]   gnt_q;
  logic              valid_q;
  logic [WIDTH-1:0]  data_q;
  logic              lrst_q;
  logic              len_q;
  logic [PW-1:0]     win_d;
  logic [PW-1:0]     ptr_d;
  logic              lock_w;

`ifdef LFSR_LOCKUP_DET_EN
  logic              pend_q;
  logic [7:0]        lock_cnt_q;
`endif

  // Modulo-NREQ addition for small offsets.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Round-robin pick: first set req bit at or after the pointer; scanning
  // from the far end lets the highest-priority hit overwrite the rest.
  always_comb begin
    win_d = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr_q, i)]) win_d = wrap_add(ptr_q, i);
    end
    ptr_d = wrap_add(idx_q, 1);
  end

`ifdef LFSR_LOCKUP_DET_EN
  // The grant register is set before the stepped value is visible, so a
  // zero value in GRANT masks the pulse in the same cycle.
  assign lock_w     = (state_q == S_GRANT) && (lfsr_value == '0);
  assign lockup_cnt = lock_cnt_q;
`else
  assign lock_w     = 1'b0;
`endif

  assign gnt         = lock_w ? '0 : gnt_q;
  assign rnd_valid   = valid_q & ~lock_w;
  // The LFSR has already stepped when GRANT is reached, so the word is
  // passed through in the grant cycle and captured for holding afterwards.
  assign rnd_data    = rnd_valid ? lfsr_value : data_q;
  assign busy        = (state_q != S_IDLE);
  assign lfsr_reset  = lrst_q;
  assign lfsr_enable = len_q;
  assign dbg_state   = state_q;

  // Main sequencer FSM with registered grant and LFSR control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lrst_q     <= 1'b1;
      len_q      <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
      pend_q     <= 1'b0;
      lock_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_INIT: begin
          if (cnt_q == RST_LAST) begin
            cnt_q   <= '0;
            lrst_q  <= 1'b0;
            len_q   <= 1'b1;
            state_q <= S_WARM;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        S_WARM: begin
          if (cnt_q == WARM_LAST) begin
            cnt_q   <= '0;
            len_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        S_IDLE: begin
`ifdef LFSR_LOCKUP_DET_EN
          if (pend_q) begin
            pend_q  <= 1'b0;
            len_q   <= 1'b1;
            state_q <= S_STEP;
          end else
`endif
          if (|req) begin
            idx_q   <= win_d;
            len_q   <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          len_q   <= 1'b0;
          gnt_q   <= NREQ'(1) << idx_q;
          valid_q <= 1'b1;
          state_q <= S_GRANT;
        end
        S_GRANT: begin
          gnt_q   <= '0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
`ifdef LFSR_LOCKUP_DET_EN
          if (lfsr_value == '0) begin
            if (lock_cnt_q != 8'hFF) lock_cnt_q <= lock_cnt_q + 8'd1;
            pend_q  <= 1'b1;
            cnt_q   <= '0;
            lrst_q  <= 1'b1;
            state_q <= S_INIT;
          end else begin
            data_q  <= lfsr_value;
            ptr_q   <= ptr_d;
          end
`else
          data_q  <= lfsr_value;
          ptr_q   <= ptr_d;
`endif
        end
        default: begin
          state_q <= S_INIT;
          cnt_q   <= '0;
          lrst_q  <= 1'b1;
          len_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Testbench for lfsr_rng_arbiter: an 8-bit maximal-length LFSR model sits on
// the LFSR side; expected grants are queued when requests are driven and
// popped by a monitor whenever the DUT pulses rnd_valid/gnt.
module tb_lfsr_rng_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    rnd_data;
  logic            rnd_valid;
  logic            busy;
  logic            lfsr_reset;
  logic            lfsr_enable;
  logic [W-1:0]    lfsr_val;
  logic [2:0]      dbg_state;
`ifdef LFSR_LOCKUP_DET_EN
  logic [7:0]      lockup_cnt;
`endif

  logic [W-1:0]    lfsr_q;
  logic            force_zero;
  logic [NREQ-1:0] exp_q[$];
  int              checks;
  int              errors;

  lfsr_rng_arbiter #(.NREQ(NREQ), .WIDTH(W), .RST_CYC(2), .WARMUP(16)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .busy(busy), .lfsr_reset(lfsr_reset),
    .lfsr_enable(lfsr_enable), .lfsr_value(lfsr_val), .dbg_state(dbg_state)
`ifdef LFSR_LOCKUP_DET_EN
    , .lockup_cnt(lockup_cnt)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // External LFSR core model: x^8+x^6+x^5+x^4+1, seed 1 on lfsr_reset
  always @(posedge clk) begin
    if (lfsr_reset) lfsr_q <= 8'h01;
    else if (lfsr_enable) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign lfsr_val = force_zero ? 8'h00 : lfsr_q;

  // Scoreboard monitor: every grant pops one expected one-hot grant
  always @(posedge clk) begin
    logic [NREQ-1:0] e;
    #1;
    if (!reset && (rnd_valid || gnt != '0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_gnt got=%b required=none", gnt);
      end else begin
        e = exp_q.pop_front();
        if (gnt !== e) begin
          errors++;
          $display("FAIL sb_gnt got=%b required=%b", gnt, e);
        end
      end
      checks++;
      if (rnd_valid !== 1'b1 || gnt == '0) begin
        errors++;
        $display("FAIL sb_valid_vs_gnt rnd_valid=%b gnt=%b required valid=1 with gnt!=0", rnd_valid, gnt);
      end
      checks++;
      if (rnd_data !== lfsr_val) begin
        errors++;
        $display("FAIL sb_rnd_data got=%h required=%h", rnd_data, lfsr_val);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, budget);
    end
  endtask

  task automatic do_init();
    reset = 1'b1;
    req = '0;
    force_zero = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    wait_idle(60);
    exp_q.delete();
  endtask

  // Called right after reset release: checks the INIT/WARM output timeline
  task automatic check_init_seq();
    logic lr, en, bz;
    for (int c = 1; c <= 22; c++) begin
      tick();
      lr = (c <= 2);
      en = (c >= 3 && c <= 18);
      bz = (c <= 18);
      checks++;
      if (lfsr_reset !== lr) begin
        errors++;
        $display("FAIL init_lfsr_reset cycle=%0d got=%b required=%b", c, lfsr_reset, lr);
      end
      checks++;
      if (lfsr_enable !== en) begin
        errors++;
        $display("FAIL init_lfsr_enable cycle=%0d got=%b required=%b", c, lfsr_enable, en);
      end
      checks++;
      if (busy !== bz) begin
        errors++;
        $display("FAIL init_busy cycle=%0d got=%b required=%b", c, busy, bz);
      end
      checks++;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL init_gnt cycle=%0d got=%b required=0", c, gnt);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (gnt !== '0 || rnd_valid !== 1'b0 || rnd_data !== '0) begin
      errors++;
      $display("FAIL %s_data_outs gnt=%b valid=%b data=%h required 0/0/00", tag, gnt, rnd_valid, rnd_data);
    end
    checks++;
    if (busy !== 1'b1 || lfsr_reset !== 1'b1 || lfsr_enable !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl_outs busy=%b lrst=%b len=%b required 1/1/0", tag, busy, lfsr_reset, lfsr_enable);
    end
`ifdef LFSR_LOCKUP_DET_EN
    checks++;
    if (lockup_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s_lockup_cnt got=%0d required=0", tag, lockup_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    force_zero = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    check_init_seq();
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    req = '0;
    checks++;
    if (lfsr_enable !== 1'b1 || gnt !== '0) begin
      errors++;
      $display("FAIL single_step len=%b gnt=%b required len=1 gnt=0000", lfsr_enable, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || rnd_valid !== 1'b1 || lfsr_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_grant gnt=%b valid=%b len=%b required 0001/1/0", gnt, rnd_valid, lfsr_enable);
    end
    checks++;
    if (rnd_data !== lfsr_val) begin
      errors++;
      $display("FAIL single_data got=%h required=%h", rnd_data, lfsr_val);
    end
    d = lfsr_val;
    tick();
    tick();
    checks++;
    if (rnd_valid !== 1'b0 || rnd_data !== d || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_hold valid=%b data=%h pending=%0d required 0/%h/0", rnd_valid, rnd_data, exp_q.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    checks++;
    if (lfsr_enable !== 1'b1) begin
      errors++;
      $display("FAIL rmid_step len=%b required=1", lfsr_enable);
    end
    reset = 1'b1;
    #1;
    check_reset_values("rmid_async");
    exp_q.delete();
    req = '0;
    tick();
    check_reset_values("rmid_held");
    reset = 1'b0;
    check_init_seq();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] vals[12];
    int n, en, cyc;
    bit dup;
    do_init();
    for (int k = 0; k < 12; k++) exp_q.push_back(4'b0001 << (k % 4));
    n = 0;
    en = 0;
    cyc = 0;
    req = 4'b1111;
    while (n < 12 && cyc < 100) begin
      tick();
      cyc++;
      if (lfsr_enable) en++;
      if (rnd_valid) begin
        vals[n] = rnd_data;
        n++;
        if (n == 12) req = '0;
      end
    end
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (lfsr_enable) en++;
    end
    checks++;
    if (n != 12 || en != 12) begin
      errors++;
      $display("FAIL rr_counts grants=%0d enables=%0d required 12/12", n, en);
    end
    dup = 1'b0;
    for (int i = 0; i < 12; i++)
      for (int j = i + 1; j < 12; j++)
        if (vals[i] == vals[j]) dup = 1'b1;
    checks++;
    if (dup) begin
      errors++;
      $display("FAIL rr_distinct repeated word=1 required=0");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_sparse();
    int g, cyc;
    do_init();
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    g = 0;
    cyc = 0;
    req = 4'b1010;
    while (g < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (g == 1 && lfsr_enable) req[3] = 1'b0;
      if (rnd_valid) begin
        g++;
        if (g == 2) begin
          checks++;
          if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL sparse_dropped_req gnt=%b required=1000", gnt);
          end
        end
        if (g == 3) req = '0;
      end
    end
    req = '0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (g != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sparse_count grants=%0d pending=%0d required 3/0", g, exp_q.size());
    end
  endtask

  task automatic test_lockup();
    int cyc;
    do_init();
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    force_zero = 1'b1;
    tick();
`ifdef LFSR_LOCKUP_DET_EN
    checks++;
    if (gnt !== '0 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_no_gnt gnt=%b valid=%b required 0000/0", gnt, rnd_valid);
    end
    tick();
    force_zero = 1'b0;
    checks++;
    if (lockup_cnt !== 8'd1 || lfsr_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_reinit cnt=%0d lrst=%b busy=%b required 1/1/1", lockup_cnt, lfsr_reset, busy);
    end
    req = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 80) begin
      tick();
      cyc++;
    end
    req = '0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lock_regrant pending=%0d required=0", exp_q.size());
    end
`else
    checks++;
    if (gnt !== 4'b0100 || rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL zero_word gnt=%b valid=%b data=%h required 0100/1/00", gnt, rnd_valid, rnd_data);
    end
    req = '0;
    tick();
    force_zero = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL zero_pending got=%0d required=0", exp_q.size());
    end
`endif
  endtask

  // Sequencer and final report
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req = '0;
    force_zero = 1'b0;
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_sparse();
    test_lockup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
